start_stop_conditioner: RTL and testbench

Front-end conditioner that turns raw, asynchronous start/stop pushbutton levels into clean single-cycle `start` and `stop` pulses for the run/idle FSM controller directly downstream. Each button is synchronized, debounced by a per-channel state machine and edge-detected. Conflicts are arbitrated so the controller never sees both commands in the same cycle.

---
 rtl/start_stop_conditioner.sv | 94 +++++++++
 tb/tb_start_stop_conditioner.sv | 89 ++++++++
 2 files changed

// File: rtl/start_stop_conditioner.sv
// start_stop_conditioner: sync, debounce and edge-detect start/stop buttons into arbitrated one-cycle pulses (optional HOLDOFF_EN lockout)
module start_stop_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_stop,
  output logic start,
  output logic stop
);
  typedef enum logic [1:0] {IDLE, CONF_PRESS, PRESSED, CONF_REL} state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || HOLDOFF_CYCLES < 1) begin : g_bad_param
    $error("start_stop_conditioner: illegal parameter value");
  end
  logic [1:0] btn;
  logic [SYNC_STAGES-1:0] sync_q [2];
  state_t st_q [2];
  logic [CW-1:0] cnt_q [2];
  logic [1:0] s_sync, qual, pass;
  logic start_d, stop_d;
  assign btn = {btn_stop, btn_start};
  // channel 0 is start, channel 1 is stop; qual fires on the cycle the press count is complete
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      s_sync[c] = sync_q[c][SYNC_STAGES-1];
      qual[c] = st_q[c] == CONF_PRESS && cnt_q[c] == DEB;
    end
  end
`ifdef HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] hold_q, hold_d;
  assign pass = hold_q == '0 ? qual : 2'b00;
  assign hold_d = (start_d | stop_d) ? HW'(HOLDOFF_CYCLES) : hold_q != '0 ? hold_q - 1'b1 : hold_q;
  // lockout counter reloads on every issued pulse and drains to zero
  always_ff @(posedge clk) hold_q <= rst ? '0 : hold_d;
`else
  assign pass = qual;
`endif
  // stop wins a tie; the losing start is dropped, not deferred
  assign stop_d = pass[1];
  assign start_d = pass[0] & ~pass[1];
  // synchronizers, debounce FSMs and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        sync_q[c] <= '0;
        st_q[c] <= IDLE;
        cnt_q[c] <= '0;
      end
      start <= 1'b0;
      stop <= 1'b0;
    end else begin
      start <= start_d;
      stop <= stop_d;
      for (int c = 0; c < 2; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], btn[c]};
        case (st_q[c])
          IDLE: if (s_sync[c]) begin
            st_q[c] <= CONF_PRESS;
            cnt_q[c] <= ONE;
          end
          CONF_PRESS: if (cnt_q[c] == DEB) begin
            st_q[c] <= PRESSED;
            cnt_q[c] <= '0;
          end else if (!s_sync[c]) begin
            st_q[c] <= IDLE;
            cnt_q[c] <= '0;
          end else cnt_q[c] <= cnt_q[c] + ONE;
          PRESSED: if (!s_sync[c]) begin
            st_q[c] <= CONF_REL;
            cnt_q[c] <= ONE;
          end
          CONF_REL: if (cnt_q[c] == DEB) begin
            st_q[c] <= s_sync[c] ? CONF_PRESS : IDLE;
            cnt_q[c] <= s_sync[c] ? ONE : '0;
          end else if (s_sync[c]) begin
            st_q[c] <= PRESSED;
            cnt_q[c] <= '0;
          end else cnt_q[c] <= cnt_q[c] + ONE;
          default: begin
            st_q[c] <= IDLE;
            cnt_q[c] <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_start_stop_conditioner.sv
// tb_start_stop_conditioner: directed checks of pulse timing, glitch rejection, arbitration and reset
module tb_start_stop_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0;
  logic btn_stop = 1'b0;
  logic start, stop;
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  string scen = "reset";
  start_stop_conditioner dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_stop(btn_stop),
    .start(start), .stop(stop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s %s edge=%0d observed=%b expected=%b", scen, tag, edge_n, obs, exp);
    end
  endtask
  // drive buttons at a falling edge; the next rising edge is edge_n, outputs checked after each edge
  task automatic step(input logic bs, input logic bp, input int n, input int s_at, input int p_at);
    btn_start = bs;
    btn_stop = bp;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("start", start, edge_n == s_at);
      chk("stop", stop, edge_n == p_at);
      edge_n++;
    end
  endtask
  initial begin
    step(0, 0, 3, -1, -1);
    rst = 1'b0;
    scen = "clean_press"; edge_n = 0;
    step(1, 0, 57, 6, -1);
    step(0, 0, 10, -1, -1);
    scen = "glitch"; edge_n = 0;
    step(0, 1, 3, -1, -1);
    step(0, 0, 2, -1, -1);
    step(0, 1, 3, -1, -1);
    step(0, 0, 12, -1, -1);
    scen = "repress"; edge_n = 0;
    step(1, 0, 8, 6, -1);
    step(0, 0, 4, -1, -1);
    step(1, 0, 4, -1, -1);
    step(0, 0, 15, 18, -1);
    scen = "short_release"; edge_n = 0;
    step(1, 0, 8, 6, -1);
    step(0, 0, 2, -1, -1);
    step(1, 0, 8, -1, -1);
    step(0, 0, 12, -1, -1);
    scen = "simultaneous"; edge_n = 0;
    step(1, 1, 10, -1, 6);
    step(0, 0, 12, -1, -1);
    scen = "reset_mid"; edge_n = 0;
    step(1, 0, 5, -1, -1);
    rst = 1'b1;
    step(1, 0, 3, -1, -1);
    rst = 1'b0;
    edge_n = 0;
    step(1, 0, 12, 6, -1);
    step(0, 0, 10, -1, -1);
    scen = "reset_suppress"; edge_n = 0;
    step(1, 0, 6, -1, -1);
    rst = 1'b1;
    step(1, 0, 2, -1, -1);
    rst = 1'b0;
    edge_n = 0;
    step(1, 0, 12, 6, -1);
    step(0, 0, 10, -1, -1);
`ifdef HOLDOFF_EN
    scen = "holdoff_drop"; edge_n = 0;
    step(1, 0, 3, -1, -1);
    step(1, 1, 25, 6, -1);
    step(0, 0, 15, -1, -1);
    scen = "holdoff_pass"; edge_n = 0;
    step(1, 0, 9, 6, -1);
    step(1, 1, 12, -1, 15);
    step(0, 0, 15, -1, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
